// File: rtl/multi_port_register_file.sv
// Multi-port register file with write forwarding, a busy scoreboard
// and same-register write conflict detection.
module multi_port_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 8,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter int BYPASS     = 1,
   localparam int AW        = $clog2(REG_NUM)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_RD*AW-1:0]         rdNum,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdData,
   input  logic [NUM_WR-1:0]            wrEn,
   input  logic [NUM_WR*AW-1:0]         wrNum,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wrData,
   input  logic                         allocEn,
   input  logic [AW-1:0]                allocNum,
   output logic [REG_NUM-1:0]           busy,
   output logic                         wrConflict
);

   logic [DATA_WIDTH-1:0] regs [REG_NUM];
   logic [REG_NUM-1:0]    busyNext;
   logic                  conflictNext;

   // Ascending port order: the higher-index port wins a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < REG_NUM; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (wrEn[p] && (wrNum[p*AW +: AW] != '0)) begin
               regs[wrNum[p*AW +: AW]] <= wrData[p*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_comb begin
      rdData = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (!rst) begin
            rdData[i*DATA_WIDTH +: DATA_WIDTH] = regs[rdNum[i*AW +: AW]];
            if (BYPASS != 0 && rdNum[i*AW +: AW] != '0) begin
               for (int p = 0; p < NUM_WR; p++) begin
                  if (wrEn[p] && wrNum[p*AW +: AW] == rdNum[i*AW +: AW]) begin
                     rdData[i*DATA_WIDTH +: DATA_WIDTH] =
                        wrData[p*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
         end
      end
   end

   // Completion clears first, then a new alloc re-marks the register.
   always_comb begin
      busyNext = busy;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wrEn[p]) begin
            busyNext[wrNum[p*AW +: AW]] = 1'b0;
         end
      end
      if (allocEn) begin
         busyNext[allocNum] = 1'b1;
      end
      busyNext[0] = 1'b0;
   end

   always_comb begin
      conflictNext = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (wrEn[p] && wrEn[q] &&
                wrNum[p*AW +: AW] == wrNum[q*AW +: AW] &&
                wrNum[p*AW +: AW] != '0) begin
               conflictNext = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= '0;
         wrConflict <= 1'b0;
      end else begin
         busy       <= busyNext;
         wrConflict <= conflictNext;
      end
   end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed bench for multi_port_register_file: bypass and non-bypass
// instances share stimulus.
module tb_multi_port_register_file;

   logic        clk;
   logic        rst;
   logic [5:0]  rdNum;
   logic [63:0] rdData;
   logic [63:0] rdDataNb;
   logic [1:0]  wrEn;
   logic [5:0]  wrNum;
   logic [63:0] wrData;
   logic        allocEn;
   logic [2:0]  allocNum;
   logic [7:0]  busy;
   logic [7:0]  busyNb;
   logic        wrConflict;
   logic        wrConflictNb;

   int nChecks;
   int nPass;

   multi_port_register_file #(.BYPASS(1)) dut (
      .clk(clk), .rst(rst), .rdNum(rdNum), .rdData(rdData),
      .wrEn(wrEn), .wrNum(wrNum), .wrData(wrData),
      .allocEn(allocEn), .allocNum(allocNum),
      .busy(busy), .wrConflict(wrConflict)
   );

   multi_port_register_file #(.BYPASS(0)) dutNb (
      .clk(clk), .rst(rst), .rdNum(rdNum), .rdData(rdDataNb),
      .wrEn(wrEn), .wrNum(wrNum), .wrData(wrData),
      .allocEn(allocEn), .allocNum(allocNum),
      .busy(busyNb), .wrConflict(wrConflictNb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wrEn    = 2'b00;
      wrNum   = '0;
      wrData  = '0;
      allocEn = 1'b0;
      allocNum = '0;
   endtask

   task automatic wr(input int p, input logic [2:0] n, input logic [31:0] d);
      wrEn[p] = 1'b1;
      wrNum[p*3 +: 3] = n;
      wrData[p*32 +: 32] = d;
   endtask

   task automatic rd(input logic [2:0] n0, input logic [2:0] n1);
      rdNum = {n1, n0};
      #1;
   endtask

   initial begin
      nChecks = 0;
      nPass   = 0;
      idle();
      rdNum = '0;
      rst = 1'b1;
      #2;
      check("rst_busy", busy, 8'h00);
      check("rst_conf", wrConflict, 1'b0);
      wr(0, 3'd3, 32'hDEAD);
      allocEn = 1'b1; allocNum = 3'd3;
      rd(3'd3, 3'd0);
      check("rst_nobypass", rdData, 64'h0);
      tick();
      check("rst_nowrite_busy", busy, 8'h00);
      rst = 1'b0;
      idle();
      rd(3'd3, 3'd0);
      check("rst_nowrite_data", rdData, 64'h0);

      wr(0, 3'd3, 32'h0000_00A5);
      tick();
      idle();
      rd(3'd3, 3'd0);
      check("basic", rdData, {32'h0, 32'h0000_00A5});
      check("basic_nb", rdDataNb, {32'h0, 32'h0000_00A5});

      wr(0, 3'd0, 32'hFFFF_FFFF);
      allocEn = 1'b1; allocNum = 3'd0;
      rd(3'd0, 3'd0);
      check("zero_bypass", rdData, 64'h0);
      tick();
      idle();
      rd(3'd0, 3'd0);
      check("zero_read", rdData, 64'h0);
      check("zero_busy", busy, 8'h00);

      wr(1, 3'd5, 32'h1234);
      rd(3'd5, 3'd3);
      check("bypass", rdData, {32'h0000_00A5, 32'h0000_1234});
      check("nobypass_old", rdDataNb, {32'h0000_00A5, 32'h0});
      tick();
      idle();
      rd(3'd5, 3'd5);
      check("nobypass_new", rdDataNb, {32'h1234, 32'h1234});

      wr(0, 3'd2, 32'h11);
      wr(1, 3'd2, 32'h22);
      rd(3'd2, 3'd0);
      check("conf_bypass", rdData, {32'h0, 32'h22});
      tick();
      idle();
      rd(3'd2, 3'd0);
      check("conf_data", rdData, {32'h0, 32'h22});
      check("conf_flag1", wrConflict, 1'b1);
      tick();
      check("conf_flag0", wrConflict, 1'b0);

      allocEn = 1'b1; allocNum = 3'd4;
      tick();
      idle();
      check("sb_alloc", busy, 8'h10);
      allocEn = 1'b1; allocNum = 3'd4;
      wr(0, 3'd4, 32'h44);
      tick();
      idle();
      check("sb_setwins", busy, 8'h10);
      rd(3'd4, 3'd0);
      check("sb_data", rdData, {32'h0, 32'h44});
      wr(0, 3'd4, 32'h45);
      tick();
      idle();
      check("sb_clear", busy, 8'h00);
      allocEn = 1'b1; allocNum = 3'd6;
      tick();
      tick();
      idle();
      check("sb_realloc", busy, 8'h40);
      wr(1, 3'd7, 32'h77);
      tick();
      idle();
      check("sb_nonbusy_wr", busy, 8'h40);

      for (int k = 1; k < 8; k++) begin
         idle();
         wr(0, k[2:0], 32'h1000 + k);
         allocEn = 1'b1; allocNum = k[2:0];
         if (k == 7) wr(1, 3'd7, 32'h2007);
         tick();
      end
      idle();
      check("pre_busy", busy, 8'hFE);
      check("pre_conf", wrConflict, 1'b1);
      rd(3'd7, 3'd1);
      check("pre_data", rdData, {32'h1001, 32'h2007});
      wr(0, 3'd3, 32'hBEEF);
      allocEn = 1'b1; allocNum = 3'd2;
      rst = 1'b1;
      #1;
      check("async_busy", busy, 8'h00);
      check("async_conf", wrConflict, 1'b0);
      rd(3'd3, 3'd7);
      check("async_rd", rdData, 64'h0);
      tick();
      rst = 1'b0;
      idle();
      rd(3'd1, 3'd6);
      check("post_rd16", rdData, 64'h0);
      rd(3'd3, 3'd7);
      check("post_rd37", rdDataNb, 64'h0);
      check("post_busy", busy, 8'h00);

      rst = 1'b1;
      #2;
      rst = 1'b0;
      wr(0, 3'd1, 32'h99);
      allocEn = 1'b1; allocNum = 3'd5;
      tick();
      idle();
      rd(3'd1, 3'd0);
      check("release_wr", rdDataNb, {32'h0, 32'h99});
      check("release_alloc", busy, 8'h20);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
